// File: rtl/ysyx_25020037_lsu_pkg.sv
// ysyx_25020037_lsu_pkg: shared bus width, access-size one-hot codes and LSU state encoding
package ysyx_25020037_lsu_pkg;
  localparam int LU_TO_WU_BUS_WD = 64;
  localparam logic [2:0] SZ_B = 3'b001;
  localparam logic [2:0] SZ_H = 3'b010;
  localparam logic [2:0] SZ_W = 3'b100;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// ysyx_25020037_lsu_align: store lane strobes/data and misalignment detection (non-one-hot size means word)
module ysyx_25020037_lsu_align
  import ysyx_25020037_lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        misaligned
);
  logic is_b, is_h;
  always_comb begin
    is_b = size == SZ_B;
    is_h = size == SZ_H;
    wstrb = is_b ? 4'b0001 << off : is_h ? 4'b0011 << off : 4'b1111;
    wdata = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
    misaligned = is_h ? off[0] : (!is_b && off != 2'd0);
  end
endmodule

// File: rtl/ysyx_25020037_lsu.sv
// ysyx_25020037_lsu: load/store unit between EXU and WBU with single-port memory handshake.
// Define YSYX_25020037_LSU_MISALIGN_CHECK_EN to fault misaligned half/word accesses without touching memory.
module ysyx_25020037_lsu
  import ysyx_25020037_lsu_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exu_valid,
  output logic                       lsu_ready,
  input  logic                       inst_l,
  input  logic                       inst_s,
  input  logic [2:0]                 lw_lh_lb,
  input  logic [31:0]                exu_result,
  input  logic [31:0]                store_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_rsp_err,
  output logic                       lsu_valid,
  input  logic                       wbu_ready,
  output logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus,
  output logic                       lsu_err
);
`ifdef YSYX_25020037_LSU_MISALIGN_CHECK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif
  lsu_state_t state, state_n;
  logic [31:0] addr_q, wdata_q, cnt;
  logic [3:0] wstrb_q, wstrb_a;
  logic [31:0] wdata_a;
  logic mis_a, ld_q, we_q, err_q, take, is_mem, skip, tmo;
  logic [LU_TO_WU_BUS_WD-1:0] bus_q;
  ysyx_25020037_lsu_align u_align (
    .size(lw_lh_lb),
    .off(exu_result[1:0]),
    .store_data(store_data),
    .wstrb(wstrb_a),
    .wdata(wdata_a),
    .misaligned(mis_a)
  );
  always_comb begin
    take = exu_valid && state == IDLE;
    is_mem = inst_l || inst_s;
    skip = is_mem && mis_a && MIS_CHK;
    tmo = MEM_TIMEOUT != 0 && cnt == 32'(MEM_TIMEOUT - 1);
    state_n = state;
    unique case (state)
      IDLE: state_n = take ? ((is_mem && !skip) ? REQ : DONE) : IDLE;
      REQ:  state_n = mem_req_ready ? RESP : REQ;
      RESP: state_n = (mem_rsp_valid || tmo) ? DONE : RESP;
      DONE: state_n = wbu_ready ? IDLE : DONE;
    endcase
    lsu_ready = state == IDLE;
    lsu_valid = state == DONE;
    mem_req_valid = state == REQ;
    mem_we = mem_req_valid && we_q;
    mem_addr = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = mem_we ? wstrb_q : 4'b0000;
    lu_to_wu_bus = bus_q;
    lsu_err = err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ld_q <= 1'b0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      bus_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        addr_q <= exu_result;
        wdata_q <= wdata_a;
        wstrb_q <= wstrb_a;
        ld_q <= inst_l;
        we_q <= inst_s && !inst_l;
        cnt <= '0;
        err_q <= skip;
        bus_q <= {exu_result, is_mem ? ERR_RDATA : exu_result};
      end
      if (state == RESP) begin
        cnt <= cnt + 32'd1;
        if (mem_rsp_valid) begin
          bus_q <= {addr_q, mem_rsp_err ? ERR_RDATA : (ld_q ? mem_rdata : 32'h0)};
          err_q <= mem_rsp_err;
        end else if (tmo) begin
          bus_q <= {addr_q, ERR_RDATA};
          err_q <= 1'b1;
        end
      end
      if (state == DONE && wbu_ready) err_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// tb_ysyx_25020037_lsu: directed bench with a lane-level behavioural model and a per-cycle compare process
module tb_ysyx_25020037_lsu;
`ifdef YSYX_25020037_LSU_MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic exu_valid = 0, inst_l = 0, inst_s = 0;
  logic [2:0] lw_lh_lb = 3'b100;
  logic [31:0] exu_result = 0, store_data = 0, mem_rdata = 0;
  logic mem_req_ready = 0, mem_rsp_valid = 0, mem_rsp_err = 0, wbu_ready = 0;
  logic lsu_ready, mem_req_valid, mem_we, lsu_valid, lsu_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_wstrb;
  logic [63:0] lu_to_wu_bus;
  int total = 0, bad = 0, cyc_cnt = 0;
  bit exp_no_req = 1, exp_we = 0, seen_req = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, seen_wdata = 0;
  logic [3:0] exp_wstrb = 0, seen_wstrb = 0;
  logic [63:0] exp_bus = 0;
  bit exp_err = 0;

  ysyx_25020037_lsu dut (
    .clk(clk), .rst(rst), .exu_valid(exu_valid), .lsu_ready(lsu_ready),
    .inst_l(inst_l), .inst_s(inst_s), .lw_lh_lb(lw_lh_lb), .exu_result(exu_result),
    .store_data(store_data), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .mem_rsp_err(mem_rsp_err),
    .lsu_valid(lsu_valid), .wbu_ready(wbu_ready), .lu_to_wu_bus(lu_to_wu_bus), .lsu_err(lsu_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-byte-lane view of the store rules.
  function automatic void model_st(input logic [2:0] sz, input logic [1:0] off, input logic [31:0] sd,
                                   output logic [3:0] st, output logic [31:0] wd, output bit mis);
    int k, o;
    k = sz == 3'b001 ? 1 : sz == 3'b010 ? 2 : 4;
    o = int'(off);
    for (int i = 0; i < 4; i++) begin
      st[i] = (k == 4) || (i >= o && i < o + k);
      wd[8*i+:8] = k == 1 ? sd[7:0] : k == 2 ? sd[8*(i%2)+:8] : sd[8*i+:8];
    end
    mis = (k == 2 && off[0]) || (k == 4 && o != 0);
  endfunction

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (mem_req_valid) begin
        seen_req = 1;
        seen_wstrb = mem_wstrb;
        seen_wdata = mem_wdata;
        if (exp_no_req) chk("unexpected_req", 1, 0);
        else begin
          chk("mem_we", mem_we, exp_we);
          chk("mem_addr", mem_addr, exp_addr);
          chk("mem_wstrb", mem_wstrb, exp_wstrb);
          if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
        end
      end
      if (lsu_valid) begin
        chk("bus", lu_to_wu_bus, exp_bus);
        chk("err", lsu_err, exp_err);
      end
    end
  end

  task automatic do_op(input bit l, input bit s, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input bit rerr,
                       input int req_dly, input int rsp_dly, input int wbu_dly, input bit no_rsp);
    logic [3:0] st;
    logic [31:0] wd;
    bit mis, is_mem, skip;
    int n, h;
    model_st(sz, a[1:0], sd, st, wd, mis);
    is_mem = l || s;
    skip = is_mem && mis && MCHK;
    exp_no_req = !is_mem || skip;
    exp_we = s && !l;
    exp_addr = a;
    exp_wstrb = exp_we ? st : 4'b0000;
    exp_wdata = wd;
    exp_err = is_mem && (skip || no_rsp || rerr);
    exp_bus = !is_mem ? {a, a} : exp_err ? {a, 32'hDEAD_BEEF} : {a, l ? rd : 32'h0};
    seen_req = 0;
    @(negedge clk);
    chk("lsu_ready_idle", lsu_ready, 1);
    inst_l = l; inst_s = s; lw_lh_lb = sz; exu_result = a; store_data = sd; exu_valid = 1;
    @(posedge clk);
    #1 exu_valid = 0;
    if (exp_no_req) begin
      #1 chk("pass_latency", lsu_valid, 1);
    end else begin
      n = 0;
      while (!mem_req_valid && n < 10) begin @(negedge clk); n++; end
      chk("req_seen", mem_req_valid, 1);
      repeat (req_dly) @(negedge clk);
      @(negedge clk) mem_req_ready = 1;
      @(posedge clk);
      #2 chk("req_drop", mem_req_valid, 0);
      h = cyc_cnt;
      @(negedge clk) mem_req_ready = 0;
      if (!no_rsp) begin
        repeat (rsp_dly) @(negedge clk);
        mem_rsp_valid = 1; mem_rdata = rd; mem_rsp_err = rerr;
        @(negedge clk) mem_rsp_valid = 0; mem_rsp_err = 0;
      end
      n = 0;
      while (!lsu_valid && n < 400) begin @(negedge clk); n++; end
      chk("done_seen", lsu_valid, 1);
      if (no_rsp) chk("timeout_lat", (cyc_cnt - h >= 254 && cyc_cnt - h <= 256), 1);
    end
    repeat (wbu_dly) begin
      @(negedge clk);
      chk("hold_valid", lsu_valid, 1);
    end
    @(negedge clk) wbu_ready = 1;
    @(posedge clk);
    #2 chk("drop_valid", lsu_valid, 0);
    chk("ready_again", lsu_ready, 1);
    @(negedge clk) wbu_ready = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_valid", lsu_valid, 0);
    chk("rst_req", mem_req_valid, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_err", lsu_err, 0);
    chk("rst_bus", lu_to_wu_bus, 0);
    rst = 0;
    do_op(0, 0, 3'b100, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    chk("lit_pass_bus", lu_to_wu_bus, 64'h0000_1234_0000_1234);
    do_op(0, 1, 3'b001, 32'h8000_0003, 32'hAB, 0, 0, 0, 1, 0, 0);
    chk("lit_sb_wstrb", seen_wstrb, 4'b1000);
    chk("lit_sb_wdata", seen_wdata, 32'hABAB_ABAB);
    chk("lit_sb_bus", lu_to_wu_bus, 64'h8000_0003_0000_0000);
    do_op(1, 0, 3'b100, 32'h8000_0004, 0, 32'hCAFE_F00D, 0, 3, 2, 3, 0);
    chk("lit_lw_bus", lu_to_wu_bus, 64'h8000_0004_CAFE_F00D);
    do_op(1, 0, 3'b100, 32'h8000_0008, 0, 32'h1111_2222, 1, 0, 1, 0, 0);
    chk("lit_err_bus", lu_to_wu_bus, 64'h8000_0008_DEAD_BEEF);
    do_op(0, 1, 3'b010, 32'h8000_0002, 32'h1234_5678, 0, 0, 1, 0, 0, 0);
    chk("lit_sh_wstrb", seen_wstrb, 4'b1100);
    chk("lit_sh_wdata", seen_wdata, 32'h5678_5678);
    do_op(0, 1, 3'b100, 32'h10, 32'h1122_3344, 0, 0, 0, 0, 1, 0);
    do_op(0, 1, 3'b010, 32'h8000_0001, 32'hBEEF, 0, 0, 0, 0, 0, 0);
    if (MCHK) begin
      chk("lit_mis_noreq", seen_req, 0);
      chk("lit_mis_bus", lu_to_wu_bus, 64'h8000_0001_DEAD_BEEF);
    end else chk("lit_mis_wstrb", seen_wstrb, 4'b0110);
    do_op(0, 1, 3'b010, 32'h8000_0003, 32'hBEEF, 0, 0, 0, 0, 0, 0);
    do_op(0, 1, 3'b011, 32'h20, 32'hA5A5_5A5A, 0, 0, 0, 0, 0, 0);
    do_op(1, 1, 3'b100, 32'h30, 32'hFFFF_FFFF, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
    do_op(1, 0, 3'b001, 32'h41, 0, 32'h5566_7788, 0, 1, 1, 1, 0);
    do_op(0, 1, 3'b001, 32'h50, 32'h77, 0, 1, 0, 0, 0, 0);
    do_op(1, 0, 3'b100, 32'h60, 0, 0, 0, 0, 0, 0, 1);
    chk("lit_tmo_bus", lu_to_wu_bus, 64'h0000_0060_DEAD_BEEF);
    // Reset while waiting for a response, then a stray response must be ignored.
    exp_no_req = 0; exp_we = 0; exp_addr = 32'h70; exp_wstrb = 0;
    @(negedge clk);
    inst_l = 1; inst_s = 0; lw_lh_lb = 3'b100; exu_result = 32'h70; exu_valid = 1;
    @(posedge clk);
    #1 exu_valid = 0;
    @(negedge clk) mem_req_ready = 1;
    @(negedge clk) mem_req_ready = 0;
    exp_no_req = 1;
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    mem_rsp_valid = 1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk) mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_valid", lsu_valid, 0);
      chk("rr_ready", lsu_ready, 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_25020037_lsu.md
Name: ysyx_25020037_lsu

Overview:
Load/store unit that sits between the execute stage and the writeback unit in the multi-cycle core. It accepts one instruction at a time from EXU and issues at most one request on the single-port data-memory interface. It then hands one result beat to WBU on lu_to_wu_bus. For loads the beat is {byte address, raw aligned memory word}; WBU does the byte shift and sign extension. Stores are lane-aligned and strobed here.

Parameters:
MEM_TIMEOUT, 255, max cycles waiting in RESP before abort; 0 disables the timeout.
ERR_RDATA, 32'hDEAD_BEEF, data returned to WBU on a memory error or timeout.

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous, active-high reset
exu_valid  in  1  EXU has an instruction for LSU
lsu_ready  out  1  LSU can accept; transfer = exu_valid & lsu_ready
inst_l  in  1  instruction is a load
inst_s  in  1  instruction is a store
lw_lh_lb  in  3  access size one-hot: 001 byte, 010 half, 100 word
exu_result  in  32  byte address for L/S; passthrough result otherwise
store_data  in  32  rs2 value, right-justified
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_we  out  1  1 = write
mem_addr  out  32  full byte address
mem_wdata  out  32  lane-shifted store data
mem_wstrb  out  4  byte strobes
mem_rsp_valid  in  1  response beat (read data or write ack)
mem_rdata  in  32  aligned read word
mem_rsp_err  in  1  response error, sampled with mem_rsp_valid
lsu_valid  out  1  result beat for WBU
wbu_ready  in  1  WBU accepts; transfer = lsu_valid & wbu_ready
lu_to_wu_bus  out  64  [63:32] address, [31:0] data
lsu_err  out  1  error qualifier, valid with lsu_valid

Behaviour:
- Reset values: state IDLE; lsu_ready=1; lsu_valid=0; mem_req_valid=0; mem_we=0; mem_wstrb=0; lsu_err=0; lu_to_wu_bus=0; timeout counter=0. Reset in any state aborts the access immediately. A later mem_rsp_valid is ignored while in IDLE.
- States: IDLE, REQ, RESP, DONE.
- IDLE: lsu_ready=1. On transfer, register all inputs and drop lsu_ready. If inst_l|inst_s, go to REQ. Otherwise load {exu_result, exu_result} into the bus and go to DONE (1-cycle pass-through).
- REQ: mem_req_valid=1 with mem_addr, mem_we and mem_wdata/mem_wstrb held stable until mem_req_ready. On the handshake go to RESP. mem_req_valid then drops on the next edge.
- RESP: the counter increments each cycle.
  - On mem_rsp_valid: bus = {addr, inst_l ? mem_rdata : 32'b0}; lsu_err = mem_rsp_err; data = ERR_RDATA if mem_rsp_err; go to DONE.
  - If the counter reaches MEM_TIMEOUT with MEM_TIMEOUT != 0: bus = {addr, ERR_RDATA}, lsu_err=1, go to DONE.
- DONE: lsu_valid=1 and the bus is held until wbu_ready. Then lsu_valid=0, lsu_ready=1, go to IDLE. A new exu_valid cannot be accepted in the same cycle; minimum occupancy is 2 cycles.
- Store lane rules, with off = addr[1:0]:
  - byte: wstrb = 4'b0001 << off; wdata = {4{sd[7:0]}}
  - half: wstrb = 4'b0011 << off; wdata = {2{sd[15:0]}}
  - word: wstrb = 4'b1111, wdata = sd
  - Strobe bits shifted beyond bit 3 are dropped.
- Loads: mem_wstrb=0, mem_we=0.
- inst_l and inst_s both high: treated as a load.
- lw_lh_lb not one-hot: treated as word.

Optional Feature:
Macro: YSYX_25020037_LSU_MISALIGN_CHECK_EN.
- Defined: in IDLE, a half access with addr[0]=1 or a word access with off!=0 skips REQ and RESP. LSU goes directly to DONE with bus {addr, ERR_RDATA} and lsu_err=1; no memory request is issued.
- Undefined: the access is issued with the truncated strobe. lsu_err comes only from the memory or the timeout.

Decomposition:
- Shared config header: LU_TO_WU_BUS_WD (64), size one-hot constants (SZ_B, SZ_H, SZ_W) and state encodings.
- One sub-module: ysyx_25020037_lsu_align. It is purely combinational: (size, off, store_data) -> (wstrb, wdata, misaligned).

Test Plan:
- Non-memory: exu_result=32'h1234 -> lsu_valid on the cycle after acceptance, bus=64'h0000_1234_0000_1234, no mem_req_valid.
- Store byte: addr=0x8000_0003, sd=0xAB -> mem_wstrb=4'b1000, mem_wdata=0xABAB_ABAB, mem_we=1; after the ack, bus low=0.
- Load word: addr=0x8000_0004, mem_req_ready delayed 3 cycles, then rdata=0xCAFE_F00D two cycles later -> request held stable throughout; bus=0x8000_0004_CAFE_F00D; lsu_valid held until wbu_ready.
- Error: mem_rsp_err=1 on a load -> lsu_err=1, data=0xDEAD_BEEF. With no response for 255 cycles -> timeout, same output.
- Misaligned half at addr 0x...1: macro on -> no request, lsu_err=1. Macro off -> wstrb=4'b0110.
- rst asserted in RESP, then a stray mem_rsp_valid -> state IDLE, lsu_valid stays 0, lsu_ready=1.
